// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the cpu_out UART transmitter.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_ctr
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Free-running bit counter, held at zero while restart is asserted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/cpu_out_uart_tx.sv
// Watches the r15 cpu_out value and sends every new value as an 8N1 UART frame,
// with a one-deep latest-wins pending slot for values that change mid-frame.
module cpu_out_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cpu_out,
  input  logic       tx_force,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t  state_r;
  logic [7:0] last_seen_r;
  logic [7:0] pending_r;
  logic       pending_valid_r;
  logic [7:0] shift_r;
  logic [2:0] bit_idx_r;
  logic       tx_r;
  logic       overrun_r;

  logic       capture_s;
  logic       load_s;
  logic       baud_tick_s;
  logic       baud_restart_s;

  // Holding the counter in IDLE guarantees every START entry begins at count zero
  assign baud_restart_s = (state_r == IDLE);

  uart_baud_ctr #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (baud_restart_s),
    .tick    (baud_tick_s)
  );

  // Capture and load decisions for the pending slot
  always_comb begin
    capture_s = (cpu_out != last_seen_r) || tx_force;
    load_s    = 1'b0;
    if (pending_valid_r) begin
      case (state_r)
        IDLE:    load_s = 1'b1;
        STOP:    load_s = baud_tick_s;
        default: load_s = 1'b0;
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // Pending slot: a same-edge capture wins over the clear caused by a load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_seen_r     <= 8'h00;
      pending_r       <= 8'h00;
      pending_valid_r <= 1'b0;
      overrun_r       <= 1'b0;
    end else if (capture_s) begin
      last_seen_r     <= cpu_out;
      pending_r       <= cpu_out;
      pending_valid_r <= 1'b1;
      if (pending_valid_r && !load_s) begin
        overrun_r <= 1'b1;
      end
    end else if (load_s) begin
      pending_valid_r <= 1'b0;
    end
  end

  // Frame FSM with registered serial output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r <= START;
            shift_r <= pending_r;
            tx_r    <= 1'b0;
          end
        end
        START: begin
          if (baud_tick_s) begin
            state_r   <= DATA;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
          end
        end
        DATA: begin
          if (baud_tick_s) begin
            if (bit_idx_r == LAST_BIT) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end
        end
        STOP: begin
          // Back-to-back frames: go straight to START with no idle bit
          if (baud_tick_s) begin
            if (load_s) begin
              state_r <= START;
              shift_r <= pending_r;
              tx_r    <= 1'b0;
            end else begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_r;
  assign busy    = (state_r != IDLE) | pending_valid_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a UART monitor decodes tx and compares.
module tb_cpu_out_uart_tx;

  logic       clk;
  logic       reset_n;
  logic [7:0] cpu_out;
  logic       tx_force;
  logic       tx;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         frames_rx  = 0;
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'h00;

  cpu_out_uart_tx #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_out  (cpu_out),
    .tx_force (tx_force),
    .tx       (tx),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One cycle: drive point just after posedge, then wait to the sampling negedge
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      to_drive();
      @(negedge clk);
      if (!busy && !mon_active) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_wait", {31'd0, done}, 32'd1);
  endtask

  // Monitor: decode 8N1 frames at mid-bit (CLKS_PER_BIT=4), drop frames cut by reset
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        if (mon_active) begin
          mon_active = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2) begin
          check("start_bit", {31'd0, tx}, 32'd0);
        end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 2) % 4) == 0) begin
          mon_byte[(mon_cnt - 6) / 4] = tx;
        end else if (mon_cnt == 38) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          frames_rx++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
          end else begin
            check("frame_data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
          end
        end else if (mon_cnt == 39) begin
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int low_cnt;
    reset_n  = 1'b0;
    cpu_out  = 8'h00;
    tx_force = 1'b0;

    // 1. reset and quiet line
    to_drive();
    to_drive();
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    busy_cnt = 0;
    low_cnt  = 0;
    for (int i = 0; i < 100; i++) begin
      to_drive();
      @(negedge clk);
      if (busy) busy_cnt++;
      if (!tx) low_cnt++;
    end
    check("idle_tx_low_cycles", low_cnt, 32'd0);
    check("idle_busy_cycles", busy_cnt, 32'd0);

    // 2. single frame 0xA5, latency and busy length
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      to_drive();
      if (i == 0) begin
        cpu_out = 8'hA5;
        exp_q.push_back(8'hA5);
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 0) check("lat_busy_before", {31'd0, busy}, 32'd0);
      if (i == 1) check("lat_busy_pending", {31'd0, busy}, 32'd1);
      if (i == 1) check("lat_tx_still_high", {31'd0, tx}, 32'd1);
      if (i == 2) check("lat_tx_start", {31'd0, tx}, 32'd0);
    end
    check("busy_cycles_one_frame", busy_cnt, 32'd41);
    wait_idle();

    // 3. forced 0xA5 then 0x3C mid-frame: back-to-back, no overrun
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      to_drive();
      if (i == 0) begin
        tx_force = 1'b1;
        exp_q.push_back(8'hA5);
      end
      if (i == 1) tx_force = 1'b0;
      if (i == 11) begin
        cpu_out = 8'h3C;
        exp_q.push_back(8'h3C);
      end
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("busy_cycles_back_to_back", busy_cnt, 32'd81);
    check("no_overrun_single_pending", {31'd0, overrun}, 32'd0);
    wait_idle();

    // 4. several mid-frame changes: latest wins, sticky overrun
    for (int i = 0; i < 100; i++) begin
      to_drive();
      if (i == 0) begin
        cpu_out = 8'h11;
        exp_q.push_back(8'h11);
      end
      if (i == 10) cpu_out = 8'h01;
      if (i == 14) cpu_out = 8'h02;
      if (i == 18) begin
        cpu_out = 8'h03;
        exp_q.push_back(8'h03);
      end
      @(negedge clk);
      if (i == 14) check("overrun_before", {31'd0, overrun}, 32'd0);
      if (i == 15) check("overrun_set", {31'd0, overrun}, 32'd1);
    end
    wait_idle();
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // 5. tx_force resends an unchanged value; without it nothing is sent
    to_drive();
    cpu_out = 8'h5A;
    exp_q.push_back(8'h5A);
    wait_idle();
    to_drive();
    tx_force = 1'b1;
    exp_q.push_back(8'h5A);
    to_drive();
    tx_force = 1'b0;
    wait_idle();
    for (int i = 0; i < 60; i++) begin
      to_drive();
      @(negedge clk);
    end
    check("frames_after_force", frames_rx, 32'd7);
    check("overrun_still_sticky", {31'd0, overrun}, 32'd1);

    // 6. reset during DATA bit 3, then the held value is re-sent
    for (int i = 0; i < 21; i++) begin
      to_drive();
      if (i == 0) begin
        cpu_out = 8'hA5;
        exp_q.push_back(8'hA5);
      end
      if (i == 19) reset_n = 1'b0;
      if (i == 20) begin
        reset_n = 1'b1;
        exp_q.push_back(8'hA5);
      end
      @(negedge clk);
      if (i == 18) check("pre_reset_busy", {31'd0, busy}, 32'd1);
      if (i == 20) begin
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        check("midframe_reset_busy", {31'd0, busy}, 32'd0);
        check("midframe_reset_overrun", {31'd0, overrun}, 32'd0);
      end
    end
    wait_idle();
    check("frames_total", frames_rx, 32'd8);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
